// File: rtl/dlbf_pkg.sv
// Shared types and default constants for the DLBF slave readback controller.
// Holds the FSM state encoding and the default read latency / buffer sizing.
package dlbf_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_RX = 3'd1,
      READ    = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } state_e;

   localparam int RD_LATENCY = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int FIRST_ADDR = 1;

endpackage

// File: rtl/dlbf_rdctrl_fifo.sv
// Synchronous output buffer for the readback stream.
// First-word fall-through read port; exposes current occupancy.
module dlbf_rdctrl_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;
   logic             do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign data_o  = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

   // occupancy: push and pop together leave it unchanged
   always_comb begin
      cnt_d = cnt_q;
      unique case ({push_i, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // storage array, contents need no reset
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_q] <= data_i;
      end
   end

   // pointers and count
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            wr_q <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dlbf_slave_rdctrl.sv
// Port-B readback controller: streams captured words 1..N out over AXI-Stream.
// Optional DLBF_RDCTRL_AUTOSTART_EN: rxdone rising edge in IDLE acts as start.
module dlbf_slave_rdctrl #(
   parameter int TDATA_WIDTH = 64,
   parameter int ADDR_WIDTH  = 16,
   parameter int RD_LATENCY  = dlbf_pkg::RD_LATENCY,
   parameter int FIFO_DEPTH  = dlbf_pkg::FIFO_DEPTH
) (
   input  logic                   s_axis_clk,
   input  logic                   slave_rst_n,
   input  logic                   start,
   input  logic                   rxdone,
   input  logic [15:0]            word_count,
   output logic                   enb,
   output logic [7:0]             web,
   output logic [ADDR_WIDTH-1:0]  addrb,
   output logic [TDATA_WIDTH-1:0] dinb,
   input  logic [TDATA_WIDTH-1:0] doutb,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [2:0]             state_wire
);

   import dlbf_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] A_FIRST = ADDR_WIDTH'(FIRST_ADDR);

   state_e                 state_q, state_d;
   logic [15:0]            n_q, n_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [15:0]            beats_q, beats_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [RD_LATENCY-1:0]  tok_q;
   logic [CW-1:0]          infl_q, infl_d;
   logic [CW-1:0]          fifo_cnt;
   logic                   fifo_empty;
   logic [TDATA_WIDTH-1:0] fifo_data;
   logic                   issue;
   logic                   tok_out;
   logic                   beat_acc;
   logic                   credit_ok;
   logic                   start_go;

`ifdef DLBF_RDCTRL_AUTOSTART_EN
   logic rx_q;

   // previous rxdone level for edge detection
   always_ff @(posedge s_axis_clk) begin
      rx_q <= rxdone;
   end

   assign start_go = start || (rxdone && !rx_q);
`else
   assign start_go = start;
`endif

   assign tok_out   = tok_q[RD_LATENCY-1];
   assign credit_ok = ({1'b0, infl_q} + {1'b0, fifo_cnt})
                      < (CW+1)'(FIFO_DEPTH);

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = m_axis_tvalid ? fifo_data : '0;
   assign m_axis_tlast  = m_axis_tvalid && (beats_q == n_q - 16'd1);
   assign beat_acc      = m_axis_tvalid && m_axis_tready;

   assign enb        = issue;
   assign addrb      = issue ? addr_q : '0;
   assign web        = '0;
   assign dinb       = '0;
   assign busy       = (state_q == WAIT_RX) || (state_q == READ)
                       || (state_q == DRAIN);
   assign done       = done_q;
   assign err        = err_q;
   assign state_wire = state_q;

   // next-state, read issue and status update
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      addr_d  = addr_q;
      beats_d = beats_q;
      done_d  = done_q;
      err_d   = err_q;
      issue   = 1'b0;
      if (beat_acc) begin
         beats_d = beats_q + 16'd1;
      end
      if (start && (state_q != IDLE)) begin
         err_d = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (start_go) begin
               n_d     = word_count;
               addr_d  = A_FIRST;
               beats_d = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = WAIT_RX;
            end
         end
         WAIT_RX: begin
            if (rxdone) begin
               if (n_q == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (credit_ok) begin
               issue  = 1'b1;
               addr_d = addr_q + 1'b1;
               if (addr_q == ADDR_WIDTH'(n_q)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (beat_acc && m_axis_tlast) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // in-flight count tracks tokens still inside the read pipe
   always_comb begin
      infl_d = infl_q;
      unique case ({issue, tok_out})
         2'b10:   infl_d = infl_q + 1'b1;
         2'b01:   infl_d = infl_q - 1'b1;
         default: infl_d = infl_q;
      endcase
   end

   // FSM and transfer bookkeeping registers
   always_ff @(posedge s_axis_clk) begin
      if (!slave_rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         addr_q  <= A_FIRST;
         beats_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // read-valid token pipe matching the RAM latency
   always_ff @(posedge s_axis_clk) begin
      if (!slave_rst_n) begin
         tok_q  <= '0;
         infl_q <= '0;
      end else begin
         tok_q  <= {tok_q[RD_LATENCY-2:0], issue};
         infl_q <= infl_d;
      end
   end

   dlbf_rdctrl_fifo #(
      .WIDTH (TDATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (s_axis_clk),
      .rst_ni  (slave_rst_n),
      .push_i  (tok_out),
      .data_i  (doutb),
      .pop_i   (beat_acc),
      .data_o  (fifo_data),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

endmodule

// File: tb/tb_dlbf_slave_rdctrl.sv
// Bench for dlbf_slave_rdctrl: RAM model with 8-cycle latency and a beat scoreboard.
// Set DLBF_RDCTRL_AUTOSTART_EN to exercise the rxdone autostart path.
module tb_dlbf_slave_rdctrl;

   localparam int LAT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        rxdone;
   logic [15:0] wc;
   logic        enb;
   logic [7:0]  web;
   logic [15:0] addrb;
   logic [63:0] dinb;
   logic [63:0] doutb;
   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic        tlast;
   logic        busy;
   logic        done;
   logic        err;
   logic [2:0]  st;

   always #5 clk = ~clk;

   dlbf_slave_rdctrl dut (
      .s_axis_clk    (clk),
      .slave_rst_n   (rst_n),
      .start         (start),
      .rxdone        (rxdone),
      .word_count    (wc),
      .enb           (enb),
      .web           (web),
      .addrb         (addrb),
      .dinb          (dinb),
      .doutb         (doutb),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tdata  (tdata),
      .m_axis_tlast  (tlast),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .state_wire    (st)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [64:0] got,
                      input logic [64:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ram(input logic [15:0] a);
      return {a ^ 16'hA5A5, a + 16'h1234, ~a, 16'hC0DE};
   endfunction

   logic [63:0] pipe [LAT];

   always @(posedge clk) begin
      pipe[0] <= enb ? ram(addrb) : 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign doutb = pipe[LAT-1];

   logic [64:0] sb [$];
   int          cyc = 0;
   int          rmode = 0;
   int          n_iss, n_acc, max_out, forbid_cnt;
   logic        forbid;
   int          iss_addr [$];
   int          iss_cyc [$];
   int          acc_cyc [$];
   int          read_cyc, beat_cyc;
   logic [64:0] e_mon;
   logic [64:0] held;
   logic        stalled;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tready = (rmode == 0) ? 1'b1 : (cyc % 4 == 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (enb) begin
            n_iss++;
            iss_addr.push_back(int'(addrb));
            iss_cyc.push_back(cyc);
            if (forbid) forbid_cnt++;
            chk("web", 65'(web), 65'd0);
            chk("dinb", 65'(dinb), 65'd0);
         end
         if (st == 3'd2 && read_cyc < 0) read_cyc = cyc;
         if (tvalid && beat_cyc < 0) beat_cyc = cyc;
         if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
         if (stalled && tvalid) chk("stable", {tlast, tdata}, held);
         stalled = tvalid && !tready;
         held    = {tlast, tdata};
         if (tvalid && tready) begin
            acc_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               chk("extra_beat", 65'd1, 65'd0);
            end else begin
               e_mon = sb.pop_front();
               chk("tdata", 65'(tdata), 65'(e_mon[63:0]));
               chk("tlast", 65'(tlast), 65'(e_mon[64]));
            end
            n_acc++;
         end
      end
   end

   task automatic clear_stats();
      n_iss      = 0;
      n_acc      = 0;
      max_out    = 0;
      forbid_cnt = 0;
      read_cyc   = -1;
      beat_cyc   = -1;
      stalled    = 1'b0;
      iss_addr.delete();
      iss_cyc.delete();
      acc_cyc.delete();
   endtask

   task automatic do_start(input int n);
      @(posedge clk);
      #1;
      wc    = 16'(n);
      start = 1'b1;
      for (int i = 1; i <= n; i++) sb.push_back({i == n, ram(16'(i))});
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("done", 65'(done), 65'd1);
   endtask

   task automatic post(input string tag, input int n);
      repeat (3) @(negedge clk);
      chk({tag, "_sb_empty"}, 65'(sb.size()), 65'd0);
      chk({tag, "_beats"}, 65'(n_acc), 65'(n));
      chk({tag, "_issues"}, 65'(n_iss), 65'(n));
      chk({tag, "_idle"}, 65'(st), 65'd0);
      chk({tag, "_busy"}, 65'(busy), 65'd0);
   endtask

   task automatic chk_addrs(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         if (i < iss_addr.size()) begin
            chk({tag, "_addr"}, 65'(iss_addr[i]), 65'(i + 1));
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      rxdone = 1'b1;
      wc     = '0;
      forbid = 1'b0;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tvalid", 65'(tvalid), 65'd0);
      chk("rst_tdata", 65'(tdata), 65'd0);
      chk("rst_tlast", 65'(tlast), 65'd0);
      chk("rst_enb", 65'(enb), 65'd0);
      chk("rst_addrb", 65'(addrb), 65'd0);
      chk("rst_busy", 65'(busy), 65'd0);
      chk("rst_done", 65'(done), 65'd0);
      chk("rst_err", 65'(err), 65'd0);
      chk("rst_state", 65'(st), 65'd0);

      // N=5, full-rate sink
      clear_stats();
      do_start(5);
      wait_done(200);
      post("t1", 5);
      chk_addrs("t1", 5);
      for (int i = 1; i < 5; i++) begin
         if (i < iss_cyc.size()) begin
            chk("t1_addr_cyc", 65'(iss_cyc[i] - iss_cyc[0]), 65'(i));
         end
      end
      chk("t1_latency", 65'(beat_cyc - read_cyc), 65'(LAT + 1));
      if (acc_cyc.size() == 5) begin
         chk("t1_rate", 65'(acc_cyc[4] - acc_cyc[0]), 65'd4);
      end

      // N=40, sink ready 1 of 4 cycles
      clear_stats();
      rmode = 1;
      do_start(40);
      wait_done(2000);
      rmode = 0;
      post("t2", 40);
      chk_addrs("t2", 40);
      chk("t2_credit", 65'(max_out <= 16), 65'd1);

      // N=0 goes straight to DONE
      clear_stats();
      do_start(0);
      @(negedge clk);
      chk("t3_wait", 65'(st), 65'd1);
      @(negedge clk);
      chk("t3_donest", 65'(st), 65'd4);
      chk("t3_done", 65'(done), 65'd1);
      @(negedge clk);
      chk("t3_idle", 65'(st), 65'd0);
      repeat (LAT + 4) @(negedge clk);
      chk("t3_enb", 65'(n_iss), 65'd0);
      chk("t3_beats", 65'(n_acc), 65'd0);

      // hold in WAIT_RX, then a stray start during READ
      clear_stats();
      @(posedge clk);
      #1;
      rxdone = 1'b0;
      forbid = 1'b1;
      do_start(6);
      repeat (100) @(negedge clk);
      chk("t4_forbid", 65'(forbid_cnt), 65'd0);
      chk("t4_state", 65'(st), 65'd1);
      chk("t4_busy", 65'(busy), 65'd1);
      chk("t4_err0", 65'(err), 65'd0);
      @(posedge clk);
      #1;
      rxdone = 1'b1;
      forbid = 1'b0;
      @(posedge clk);
      #1;
      wc    = 16'd99;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("t4_err", 65'(err), 65'd1);
      wait_done(300);
      post("t4", 6);
      chk_addrs("t4", 6);
      chk("t4_err_sticky", 65'(err), 65'd1);

      // reset in the middle of N=20
      clear_stats();
      do_start(20);
      begin
         int k = 0;
         while (n_acc < 7 && k < 300) begin
            @(negedge clk);
            k++;
         end
         chk("t5_reach7", 65'(n_acc >= 7), 65'd1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      clear_stats();
      @(negedge clk);
      chk("t5_tvalid", 65'(tvalid), 65'd0);
      chk("t5_state", 65'(st), 65'd0);
      chk("t5_done", 65'(done), 65'd0);
      chk("t5_err", 65'(err), 65'd0);
      repeat (15) @(negedge clk);
      chk("t5_no_stale", 65'(n_acc), 65'd0);
      do_start(3);
      wait_done(200);
      post("t5", 3);
      chk_addrs("t5", 3);

`ifdef DLBF_RDCTRL_AUTOSTART_EN
      // rxdone rising edge starts a transfer on its own
      clear_stats();
      @(posedge clk);
      #1;
      rxdone = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      wc     = 16'd4;
      rxdone = 1'b1;
      for (int i = 1; i <= 4; i++) sb.push_back({i == 4, ram(16'(i))});
      @(posedge clk);
      #1;
      wait_done(200);
      post("t6", 4);
      chk_addrs("t6", 4);
`else
      // rxdone rising edge alone must not start
      clear_stats();
      @(posedge clk);
      #1;
      rxdone = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rxdone = 1'b1;
      repeat (LAT + 6) @(negedge clk);
      chk("t6_state", 65'(st), 65'd0);
      chk("t6_enb", 65'(n_iss), 65'd0);
      chk("t6_beats", 65'(n_acc), 65'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1);
   end

endmodule
